// File: rtl/fifo_channel_drainer.sv
// Multi-channel FIFO drainer: picks a channel (timed-out first, else round-robin),
// reads up to MaxBurst words from it and forwards them over a valid/ready port.
module fifo_channel_drainer #(
  parameter int Channels = 16,
  parameter int Width    = 32,
  parameter int MaxBurst = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  output logic [$clog2(Channels)-1:0] RCS,
  input  logic                        REMPTY,
  output logic                        RD,
  input  logic [Width-1:0]            DO,
  input  logic [$clog2(Channels)-1:0] STT,
  input  logic                        SKIP,
  input  logic [Channels-1:0]         CHEN,
  output logic                        OVALID,
  input  logic                        ORDY,
  output logic [Width-1:0]            ODATA,
  output logic [$clog2(Channels)-1:0] OCH,
  output logic                        OLAST,
  output logic                        BUSY
);

  localparam int ChW = $clog2(Channels);
  localparam logic [3:0] BurstMax = 4'(MaxBurst);

  typedef enum logic [1:0] {SCAN, SETTLE, CHECK, SEND} state_t;

  state_t              state_q;
  logic [ChW-1:0]      rcs_q;
  logic [ChW-1:0]      lastServed_q;
  logic [Channels-1:0] pending_q;
  logic [3:0]          burst_q;
  logic [Width-1:0]    odata_q;
  logic [ChW-1:0]      och_q;
  logic                olast_q;
  logic                ovalid_q;
  logic                rd_q;
  logic                busy_q;

  logic [ChW-1:0] pendCh;
  logic [ChW-1:0] rrCh;
  logic [ChW-1:0] rrIdx;
  logic [ChW-1:0] selCh;
  logic           pendHit;
  logic           rrHit;
  logic [3:0]     burstInc;

  assign burstInc = burst_q + 4'd1;

  // Both scans iterate from the far end so the closest qualifying channel is the last one written.
  always_comb begin
    pendCh  = '0;
    pendHit = 1'b0;
    for (int i = Channels - 1; i >= 0; i--) begin
      if (pending_q[i] && CHEN[i]) begin
        pendCh  = ChW'(i);
        pendHit = 1'b1;
      end
    end
    rrCh  = '0;
    rrHit = 1'b0;
    rrIdx = '0;
    for (int k = Channels; k >= 1; k--) begin
      rrIdx = lastServed_q + ChW'(k);
      if (CHEN[rrIdx]) begin
        rrCh  = rrIdx;
        rrHit = 1'b1;
      end
    end
    selCh = pendHit ? pendCh : rrCh;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= SCAN;
      rcs_q        <= '0;
      lastServed_q <= ChW'(Channels - 1);
      pending_q    <= '0;
      burst_q      <= '0;
      odata_q      <= '0;
      och_q        <= '0;
      olast_q      <= 1'b0;
      ovalid_q     <= 1'b0;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      case (state_q)
        SCAN: begin
          burst_q <= '0;
          if (rrHit) begin
            rcs_q   <= selCh;
            state_q <= SETTLE;
            busy_q  <= 1'b1;
          end
        end
        SETTLE: state_q <= CHECK;
        CHECK: begin
          if (REMPTY) begin
            pending_q[rcs_q] <= 1'b0;
            lastServed_q     <= rcs_q;
            state_q          <= SCAN;
            busy_q           <= 1'b0;
          end else begin
            odata_q  <= DO;
            och_q    <= rcs_q;
            rd_q     <= 1'b1;
            burst_q  <= burstInc;
            olast_q  <= (burstInc == BurstMax);
            ovalid_q <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (ORDY) begin
            ovalid_q <= 1'b0;
            if (olast_q) begin
              pending_q[rcs_q] <= 1'b0;
              lastServed_q     <= rcs_q;
              state_q          <= SCAN;
              busy_q           <= 1'b0;
            end else begin
              state_q <= SETTLE;
            end
          end
        end
        default: state_q <= SCAN;
      endcase
      // Placed last so a timeout on the channel being retired keeps its pending bit.
      if (SKIP) pending_q[STT] <= 1'b1;
    end
  end

  assign RCS    = rcs_q;
  assign RD     = rd_q;
  assign OVALID = ovalid_q;
  assign ODATA  = odata_q;
  assign OCH    = och_q;
  assign OLAST  = olast_q;
  assign BUSY   = busy_q;

endmodule

// File: doc/fifo_channel_drainer.md
FIFO_CHANNEL_DRAINER -- requirements
Module: fifo_channel_drainer

Interface
REQ-001 Parameter Channels, default 16, number of FIFO channels served; power of two, minimum 2.
REQ-002 Parameter Width, default 32, data word width.
REQ-003 Parameter MaxBurst, default 4, maximum words drained per channel visit; range 1..15.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RESET  input  1  reset, synchronous, active-low.
REQ-006 RCS  output  clogb2(Channels)  read channel select driven to the FIFO.
REQ-007 REMPTY  input  1  FIFO empty flag for the channel selected by RCS, registered (valid 1 cycle after RCS changes).
REQ-008 RD  output  1  FIFO read strobe, single-cycle pulse.
REQ-009 DO  input  Width  FIFO head word for RCS, registered (valid 1 cycle after RCS or read pointer changes).
REQ-010 STT  input  clogb2(Channels)  timed-out channel index from the FIFO.
REQ-011 SKIP  input  1  timeout strobe; qualifies STT.
REQ-012 CHEN  input  Channels  per-channel enable mask; a 0 bit excludes the channel from service.
REQ-013 OVALID  output  1  output word valid.
REQ-014 ORDY  input  1  downstream ready.
REQ-015 ODATA  output  Width  output word.
REQ-016 OCH  output  clogb2(Channels)  source channel of ODATA.
REQ-017 OLAST  output  1  ODATA is the final word of the current visit.
REQ-018 BUSY  output  1  high in every state except SCAN.

Function
REQ-019 The FSM SHALL have states SCAN, SETTLE, CHECK, SEND.
REQ-020 SCAN: the drainer selects the next channel, drives it on RCS, clears the burst counter, and moves to SETTLE.
REQ-021 Selection SHALL use this priority: first, the lowest-index channel with its pending bit set and CHEN set; otherwise, round-robin from the channel after the last served one, skipping channels with CHEN=0.
REQ-022 If no channel has CHEN set, the drainer SHALL stay in SCAN and hold RCS.
REQ-023 SETTLE: the drainer holds RCS for 1 cycle so that REMPTY and DO are valid, then moves to CHECK.
REQ-024 CHECK with REMPTY=1: the drainer clears the pending bit of the channel, records it as last served, and returns to SCAN without asserting RD.
REQ-025 CHECK with REMPTY=0: the drainer latches DO into ODATA, latches RCS into OCH, pulses RD for exactly that cycle, increments the burst counter, and moves to SEND.
REQ-026 OLAST SHALL be set in CHECK when the incremented burst counter equals MaxBurst.
REQ-027 SEND: OVALID=1; ODATA, OCH and OLAST stay stable until a cycle with OVALID and ORDY both high.
REQ-028 On the SEND handshake, if OLAST=0 the drainer moves to SETTLE on the same channel.
REQ-029 On the SEND handshake, if OLAST=1 the drainer clears the channel's pending bit, records it as last served, and moves to SCAN.
REQ-030 OVALID SHALL fall in the cycle after the handshake unless a new word is latched.
REQ-031 A channel emptied mid-burst ends the visit at the next CHECK; in that case the last word sent has OLAST=0.
REQ-032 RD SHALL never be asserted in two consecutive cycles; at least 2 cycles separate RD from the next CHECK on the same channel.
REQ-033 SKIP=1 SHALL set pending[STT] on that edge, in every state.
REQ-034 If SKIP sets a pending bit in the same cycle that the drainer clears it, the set SHALL win.
REQ-035 A CHEN bit that drops mid-visit SHALL take effect only at the next SCAN; the word already latched is still delivered.
REQ-036 Round-robin pointer arithmetic SHALL wrap modulo Channels.
REQ-037 The burst counter SHALL be 4 bits and SHALL never exceed MaxBurst.

Reset
REQ-038 With RESET=0 at an edge, the drainer SHALL set: state=SCAN, RCS=0, RD=0, OVALID=0, ODATA=0, OCH=0, OLAST=0, BUSY=0, pending=0, burst counter=0, last served=Channels-1.
REQ-039 Reset SHALL have priority over SKIP and over any handshake.
REQ-040 Reset mid-SEND SHALL drop the latched word without a handshake.

Verification
REQ-041 Channel 3 holds A,B and CHEN=all ones: the bench SHALL see ODATA A then B with OCH=3, OLAST=0 on both, two RD pulses, then a return to SCAN.
REQ-042 Channel 5 holds 6 words, MaxBurst=4: the bench SHALL see four words with OLAST on the 4th; the drainer then serves other channels before returning for the remaining 2 words.
REQ-043 ORDY held low 10 cycles during SEND: the bench SHALL see ODATA, OCH and OLAST stable and no RD until the handshake.
REQ-044 SKIP with STT=9 while serving channel 2: the next SCAN SHALL select 9 ahead of round-robin, and pending[9] SHALL clear after the visit.
REQ-045 CHEN=16'h0001 with all FIFO channels empty: the bench SHALL see RCS cycling on channel 0 only, no RD, and OVALID=0.
REQ-046 RESET low during SEND: the bench SHALL see OVALID=0 on the next cycle, pending=0 and state=SCAN.
